pcx_dest_arbctl: RTL and testbench



---
 rtl/pcx_arb_pkg.sv | 14 +
 rtl/pcx_rr_pick.sv | 49 ++++
 rtl/pcx_dest_arbctl.sv | 163 ++++++++++++++++
 tb/tb_pcx_dest_arbctl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pcx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcx_arb_pkg
//  Description : Shared sizing constants for the per-destination PCX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcx_arb_pkg;

  localparam int NSRC_DEF = 5;
  localparam int QDEPTH   = 2;
  localparam int CNT_W    = 2;

endpackage : pcx_arb_pkg
`default_nettype wire

// File: rtl/pcx_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : pcx_rr_pick
//  Description : Combinational round-robin picker; priority starts just
//                after lastgnt and wraps around to source 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcx_rr_pick
  import pcx_arb_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IW   = $clog2(NSRC_DEF)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   lastgnt,
  output logic [NSRC-1:0] gnt
);

  logic [NSRC-1:0] w_hi_mask;
  logic [NSRC-1:0] w_req_hi;

  function automatic logic [NSRC-1:0] lowest_set(input logic [NSRC-1:0] v);
    logic [NSRC-1:0] r;
    logic            f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!f && v[i]) begin
        r[i] = 1'b1;
        f    = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_hi_mask[i] = (IW'(i) > lastgnt);
    end
  end

  assign w_req_hi = req & w_hi_mask;

  // Sources above lastgnt win first; otherwise wrap to the lowest requester.
  assign gnt = (|w_req_hi) ? lowest_set(w_req_hi) : lowest_set(req);

endmodule : pcx_rr_pick
`default_nettype wire

// File: rtl/pcx_dest_arbctl.sv
`default_nettype none
// ============================================================================
//  Module      : pcx_dest_arbctl
//  Description : Per-destination PCX arbiter: round-robin grant with stall and
//                atomic-pair lock, plus per-source two-entry queue controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcx_dest_arbctl
  import pcx_arb_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic [NSRC-1:0] spc_pcx_req_pq,
  input  logic [NSRC-1:0] spc_pcx_atom_pq,
  input  logic            pcx_stall_pq,
  output logic [NSRC-1:0] arbpc_pcxdp_grant_arbbf_pa,
  output logic [NSRC-1:0] arbpc_pcxdp_q0_hold_arbbf_pa_l,
  output logic [NSRC-1:0] arbpc_pcxdp_qsel0_arbbf_pa,
  output logic [NSRC-1:0] arbpc_pcxdp_qsel1_arbbf_pa_l,
  output logic [NSRC-1:0] arbpc_pcxdp_shift_arbbf_px,
  output logic            arbpc_ovf_err
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [NSRC-1:0] r_grant;
  logic [NSRC-1:0] r_shift;
  logic [NSRC-1:0] r_req_pa;
  logic            r_lock;
  logic [IW-1:0]   r_lastgnt;
  logic            r_err;

  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_head_atm;
  logic [NSRC-1:0] w_rr_gnt;
  logic [NSRC-1:0] w_gnt;
  logic [NSRC-1:0] w_ovf;
  logic            w_lock_err;
  logic            w_lock_set;
  logic [IW-1:0]   w_gidx;

  pcx_rr_pick #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_rr_pick (
    .req     (w_elig),
    .lastgnt (r_lastgnt),
    .gnt     (w_rr_gnt)
  );

  // While locked, the previous grant names the source owed its second half.
  always_comb begin
    w_gnt      = '0;
    w_lock_err = 1'b0;
    if (r_lock) begin
      w_gnt      = r_grant & w_elig;
      w_lock_err = (w_gnt == '0);
    end else if (!pcx_stall_pq) begin
      w_gnt = w_rr_gnt;
    end
  end

  assign w_lock_set = ~r_lock & (|(w_gnt & w_head_atm));

  always_comb begin
    w_gidx = r_lastgnt;
    for (int i = 0; i < NSRC; i++) begin
      if (w_gnt[i]) w_gidx = IW'(i);
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_grant   <= '0;
      r_shift   <= '0;
      r_req_pa  <= '0;
      r_lock    <= 1'b0;
      r_lastgnt <= IW'(NSRC - 1);
      r_err     <= 1'b0;
    end else begin
      r_grant   <= w_gnt;
      r_shift   <= r_grant;
      r_req_pa  <= spc_pcx_req_pq;
      r_lock    <= w_lock_set;
      r_lastgnt <= w_gidx;
      r_err     <= r_err | (|w_ovf) | w_lock_err;
    end
  end

  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      logic [CNT_W-1:0] r_pend;
      logic [CNT_W-1:0] r_occ;
      logic [1:0]       r_atm;
      logic [CNT_W-1:0] w_pend_n;
      logic [1:0]       w_atm_n;
      logic [CNT_W-1:0] w_occ_sh;
      logic [CNT_W-1:0] w_occ_n;
      logic             w_ovf_pend;
      logic             w_ovf_occ;

      assign w_elig[s]     = (r_pend != '0) | spc_pcx_req_pq[s];
      assign w_head_atm[s] = (r_pend != '0) ? r_atm[0] : spc_pcx_atom_pq[s];

      // A request granted in its own cycle bypasses the pending FIFO.
      always_comb begin
        w_pend_n   = r_pend;
        w_atm_n    = r_atm;
        w_ovf_pend = 1'b0;
        if (w_gnt[s] && (r_pend != '0)) begin
          w_pend_n = r_pend - c_one;
          w_atm_n  = {1'b0, r_atm[1]};
        end
        if (spc_pcx_req_pq[s] && !(w_gnt[s] && (r_pend == '0))) begin
          if (w_pend_n == c_full) begin
            w_ovf_pend = 1'b1;
          end else begin
            w_atm_n[w_pend_n[0]] = spc_pcx_atom_pq[s];
            w_pend_n             = w_pend_n + c_one;
          end
        end
      end

      always_comb begin
        w_occ_sh  = (r_shift[s] && (r_occ != '0)) ? (r_occ - c_one) : r_occ;
        w_occ_n   = w_occ_sh;
        w_ovf_occ = 1'b0;
        if (r_req_pa[s]) begin
          if (w_occ_sh == c_full) w_ovf_occ = 1'b1;
          else                    w_occ_n   = w_occ_sh + c_one;
        end
      end

      assign w_ovf[s] = w_ovf_pend | w_ovf_occ;

      assign arbpc_pcxdp_qsel0_arbbf_pa[s]   = r_req_pa[s] & (w_occ_sh == '0);
      assign arbpc_pcxdp_qsel1_arbbf_pa_l[s] = ~(r_req_pa[s] & (w_occ_sh == c_one));

      always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
          r_pend <= '0;
          r_occ  <= '0;
          r_atm  <= '0;
        end else begin
          r_pend <= w_pend_n;
          r_occ  <= w_occ_n;
          r_atm  <= w_atm_n;
        end
      end
    end
  endgenerate

  assign arbpc_pcxdp_grant_arbbf_pa     = r_grant;
  assign arbpc_pcxdp_shift_arbbf_px     = r_shift;
  assign arbpc_pcxdp_q0_hold_arbbf_pa_l = r_shift;
  assign arbpc_ovf_err                  = r_err;

endmodule : pcx_dest_arbctl
`default_nettype wire

// File: tb/tb_pcx_dest_arbctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcx_dest_arbctl
//  Description : Directed self-checking bench for pcx_dest_arbctl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcx_dest_arbctl;

  logic       rclk = 1'b0;
  logic       arst_l = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] atom = '0;
  logic       stall = 1'b0;
  logic [4:0] gnt, hold_l, qsel0, qsel1_l, shift;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  pcx_dest_arbctl #(.NSRC(5)) dut (
    .rclk                           (rclk),
    .arst_l                         (arst_l),
    .spc_pcx_req_pq                 (req),
    .spc_pcx_atom_pq                (atom),
    .pcx_stall_pq                   (stall),
    .arbpc_pcxdp_grant_arbbf_pa     (gnt),
    .arbpc_pcxdp_q0_hold_arbbf_pa_l (hold_l),
    .arbpc_pcxdp_qsel0_arbbf_pa     (qsel0),
    .arbpc_pcxdp_qsel1_arbbf_pa_l   (qsel1_l),
    .arbpc_pcxdp_shift_arbbf_px     (shift),
    .arbpc_ovf_err                  (err)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  // Leaves the bench at the start of the first cycle after reset release.
  task automatic reset_dut;
    @(posedge rclk);
    #1;
    arst_l = 1'b0;
    req    = '0;
    atom   = '0;
    stall  = 1'b0;
    #2;
    @(posedge rclk);
    #1;
    arst_l = 1'b1;
  endtask

  initial begin
    logic [7:0] e_g, e_s;

    // Reset values
    #12;
    chk("rst_grant",   {3'b0, gnt},     8'h00);
    chk("rst_shift",   {3'b0, shift},   8'h00);
    chk("rst_qsel0",   {3'b0, qsel0},   8'h00);
    chk("rst_qsel1_l", {3'b0, qsel1_l}, 8'h1F);
    chk("rst_hold_l",  {3'b0, hold_l},  8'h00);
    chk("rst_ovf",     {7'b0, err},     8'h00);
    @(posedge rclk);
    #1;
    arst_l = 1'b1;

    // Single request from source 2
    req = 5'b00100;
    chk("a_gnt_t0", {3'b0, gnt}, 8'h00);
    tick;
    req = '0;
    chk("a_gnt_t1",     {3'b0, gnt},     8'h04);
    chk("a_qsel0_t1",   {3'b0, qsel0},   8'h04);
    chk("a_qsel1_l_t1", {3'b0, qsel1_l}, 8'h1F);
    chk("a_hold_l_t1",  {3'b0, hold_l},  8'h00);
    tick;
    chk("a_gnt_t2",    {3'b0, gnt},    8'h00);
    chk("a_shift_t2",  {3'b0, shift},  8'h04);
    chk("a_hold_l_t2", {3'b0, hold_l}, 8'h04);
    chk("a_qsel0_t2",  {3'b0, qsel0},  8'h00);
    tick;
    chk("a_shift_t3", {3'b0, shift}, 8'h00);

    // All five sources at once: grants 0..4 in order, shifts one cycle later
    reset_dut;
    req = 5'b11111;
    tick;
    req = '0;
    chk("b_qsel0_t1", {3'b0, qsel0}, 8'h1F);
    for (int i = 1; i <= 6; i++) begin
      e_g = (i <= 5) ? (8'h01 << (i - 1)) : 8'h00;
      e_s = (i >= 2) ? (8'h01 << (i - 2)) : 8'h00;
      chk($sformatf("b_gnt_t%0d", i),   {3'b0, gnt},   e_g);
      chk($sformatf("b_shift_t%0d", i), {3'b0, shift}, e_s);
      tick;
    end

    // Stall in cycles 3..4 holds off source 1 until cycle 6
    reset_dut;
    tick; tick; tick;
    stall = 1'b1;
    req   = 5'b00010;
    chk("c_gnt_t3", {3'b0, gnt}, 8'h00);
    tick;
    req = '0;
    chk("c_gnt_t4", {3'b0, gnt}, 8'h00);
    tick;
    stall = 1'b0;
    chk("c_gnt_t5", {3'b0, gnt}, 8'h00);
    tick;
    chk("c_gnt_t6", {3'b0, gnt}, 8'h02);
    tick;

    // Atomic pair from source 3 with lastgnt=2; source 0 waits, stall ignored
    reset_dut;
    req = 5'b00100;
    tick;
    req = '0;
    tick; tick;
    req  = 5'b01001;
    atom = 5'b01000;
    tick;
    req   = 5'b01000;
    atom  = '0;
    stall = 1'b1;
    chk("d_gnt_t1", {3'b0, gnt}, 8'h08);
    tick;
    req   = '0;
    stall = 1'b0;
    chk("d_gnt_t2", {3'b0, gnt}, 8'h08);
    tick;
    chk("d_gnt_t3", {3'b0, gnt}, 8'h01);
    chk("d_ovf_t3", {7'b0, err}, 8'h00);
    tick;

    // Three requests from source 4 under stall overflow the pending count
    reset_dut;
    stall = 1'b1;
    req   = 5'b10000;
    tick;
    tick;
    chk("e_ovf_t2",     {7'b0, err},     8'h00);
    chk("e_qsel1_l_t2", {3'b0, qsel1_l}, 8'h0F);
    tick;
    req = '0;
    chk("e_ovf_t3", {7'b0, err}, 8'h01);
    tick; tick;
    chk("e_ovf_t5", {7'b0, err}, 8'h01);
    arst_l = 1'b0;
    #1;
    chk("e_ovf_after_rst", {7'b0, err}, 8'h00);
    stall = 1'b0;
    @(posedge rclk);
    #1;
    arst_l = 1'b1;

    // Source 1: new packet arrives as the held one departs (occ'=0)
    reset_dut;
    stall = 1'b1;
    req   = 5'b00010;
    tick;
    req = '0;
    chk("f_qsel0_t1", {3'b0, qsel0}, 8'h02);
    tick; tick; tick;
    stall = 1'b0;
    tick;
    chk("f_gnt_t5", {3'b0, gnt}, 8'h02);
    req = 5'b00010;
    tick;
    req = '0;
    chk("f_shift_t6",   {3'b0, shift},   8'h02);
    chk("f_qsel0_t6",   {3'b0, qsel0},   8'h02);
    chk("f_hold_l_t6",  {3'b0, hold_l},  8'h02);
    chk("f_qsel1_l_t6", {3'b0, qsel1_l}, 8'h1F);
    chk("f_gnt_t6",     {3'b0, gnt},     8'h02);
    tick;
    chk("f_shift_t7", {3'b0, shift}, 8'h02);
    chk("f_qsel0_t7", {3'b0, qsel0}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pcx_dest_arbctl
`default_nettype wire
